bcd_ex3_serial_conv: RTL and testbench
======================================

Name: bcd_ex3_serial_conv

Overview:
Parametrised, digit-serial bidirectional BCD <-> Excess-3 code converter for packed multi-digit words.
- Accepts a DIGITS-wide packed word through a valid/ready handshake.
- Converts one 4-bit digit per clock, least-significant digit first.
- Presents the result, plus a per-digit invalid-code mask, through a second valid/ready handshake.
- Sits between a numeric datapath and display/serial-code consumers; it replaces fixed-width combinational converters where width, direction or error reporting must vary.

Parameters:
DIGITS, 4, number of packed 4-bit digits per word (legal range >= 1).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  input word available.
in_ready  output  1  converter can accept a word.
mode  input  1  0 = BCD to Excess-3, 1 = Excess-3 to BCD; sampled only at input handshake.
data_in  input  4*DIGITS  packed input digits; digit k occupies bits [4k+3:4k].
out_valid  output  1  result word available.
out_ready  input  1  consumer accepts the result.
data_out  output  4*DIGITS  packed converted digits.
err_mask  output  DIGITS  bit k set = input digit k was an invalid code.
err  output  1  OR-reduction of err_mask.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n, sampled on the rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, data_out=0, err_mask=0, err=0, digit counter=0.
- Reset mid-operation: any in-flight word is discarded and no out_valid is produced for it.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid & in_ready: capture data_in and mode into internal registers, clear the counter, clear data_out/err_mask, go to CONV.
- CONV:
  - in_ready=0.
  - Each edge converts captured digit[cnt] and writes it into data_out[4cnt+3:4cnt].
  - Sets err_mask[cnt] if the digit is invalid.
  - Increments cnt. When cnt==DIGITS-1, goes to DONE.
- DONE:
  - out_valid=1. data_out, err_mask and err are held stable until out_valid & out_ready.
  - On that edge, go to IDLE; out_valid falls.
  - in_ready stays 0 throughout, so in_valid is ignored.
- Latency and throughput:
  - out_valid rises exactly DIGITS clock edges after the accepting edge.
  - With out_ready held high, throughput is one word per DIGITS+2 cycles.
- Arithmetic, per 4-bit digit:
  - mode 0: valid if d<=9; out=d+3.
  - mode 1: valid if 3<=d<=12; out=d-3.
  - Invalid digit: out=4'hF and mask bit set.
- err is combinational from err_mask and meaningful only while out_valid=1.
- The counter is at least 1 bit wide so DIGITS=1 is legal; for DIGITS=1, CONV lasts one edge.
- mode or data_in changes after the accept edge have no effect on the current word.
- out_ready asserted outside DONE is ignored.

Decomposition:
- Shared constants header (code_conv_defs.vh):
  - MODE_BCD2EX3=1'b0, MODE_EX32BCD=1'b1.
  - State encodings IDLE/CONV/DONE.
  - INVALID_DIGIT=4'hF.
- One combinational sub-module, ex3_digit_conv: inputs 4-bit digit and mode; outputs 4-bit result and invalid flag. It is instantiated once and muxed by the counter.
- FSM, counter and registers live in the top.

Test Plan:
1. DIGITS=4, mode=0, data_in=16'h1234 -> data_out=16'h4567, err_mask=4'b0000; out_valid rises 4 edges after accept.
2. mode=1, data_in=16'h3C4B -> data_out=16'h0918, err=0.
3. mode=0, data_in=16'h9A05 -> data_out=16'hCF38, err_mask=4'b0100, err=1.
4. Result in DONE with out_ready=0 for 5 cycles while in_valid=1 with new data -> data_out stable, in_ready=0, second word not captured. Raise out_ready -> IDLE next edge, then second word accepted.
5. rst_n low for one edge during CONV -> next cycle out_valid=0, in_ready=1, data_out=0. A following 16'h0999 in mode 0 -> 16'h3CCC.
6. DIGITS=1 instance: mode 0, 4'h9 -> 4'hC after 1 edge; mode 1, 4'h2 -> 4'hF, err=1.

Source files
------------

// File: rtl/bcd_ex3_serial_conv_pkg.sv
//------------------------------------------------------------------------------
// Module  : bcd_ex3_serial_conv_pkg
// Brief   : Shared code constants and FSM encoding for the BCD/Excess-3 converter.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bcd_ex3_serial_conv_pkg;

   localparam logic       MODE_BCD2EX3  = 1'b0;
   localparam logic       MODE_EX32BCD  = 1'b1;
   localparam logic [3:0] INVALID_DIGIT = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/ex3_digit_conv.sv
//------------------------------------------------------------------------------
// Module  : ex3_digit_conv
// Brief   : Combinational single-digit BCD <-> Excess-3 conversion with validity flag.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex3_digit_conv
   import bcd_ex3_serial_conv_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       mode,
   output logic [3:0] result,
   output logic       invalid
);

   logic       w_invalid;
   logic [3:0] w_sum;

   always_comb begin
      w_invalid = 1'b0;
      w_sum     = 4'h0;
      case (mode)
         MODE_BCD2EX3: begin
            w_invalid = (digit > 4'd9);
            w_sum     = digit + 4'd3;
         end
         MODE_EX32BCD: begin
            w_invalid = (digit < 4'd3) || (digit > 4'd12);
            w_sum     = digit - 4'd3;
         end
         default: begin
            w_invalid = 1'b1;
            w_sum     = INVALID_DIGIT;
         end
      endcase
   end

   assign result  = w_invalid ? INVALID_DIGIT : w_sum;
   assign invalid = w_invalid;

endmodule

`default_nettype wire

// File: rtl/bcd_ex3_serial_conv.sv
//------------------------------------------------------------------------------
// Module  : bcd_ex3_serial_conv
// Brief   : Digit-serial BCD <-> Excess-3 word converter with valid/ready handshakes.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_ex3_serial_conv
   import bcd_ex3_serial_conv_pkg::*;
#(
   parameter int DIGITS = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mode,
   input  logic [4*DIGITS-1:0]   data_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   data_out,
   output logic [DIGITS-1:0]     err_mask,
   output logic                  err
);

   // Counter kept at least one bit wide so a single-digit build stays legal.
   localparam int             CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0]  C_LAST = CW'(DIGITS - 1);

   state_t                r_state;
   logic [4*DIGITS-1:0]   r_data;
   logic                  r_mode;
   logic [CW-1:0]         r_cnt;
   logic [4*DIGITS-1:0]   r_data_out;
   logic [DIGITS-1:0]     r_err_mask;
   logic                  r_in_ready;
   logic                  r_out_valid;

   logic [3:0]            w_digit;
   logic [3:0]            w_result;
   logic                  w_invalid;

   assign w_digit = 4'(r_data >> {r_cnt, 2'b00});

   ex3_digit_conv u_digit_conv (
      .digit   (w_digit),
      .mode    (r_mode),
      .result  (w_result),
      .invalid (w_invalid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_data      <= '0;
         r_mode      <= MODE_BCD2EX3;
         r_cnt       <= '0;
         r_data_out  <= '0;
         r_err_mask  <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_data     <= data_in;
                  r_mode     <= mode;
                  r_cnt      <= '0;
                  r_data_out <= '0;
                  r_err_mask <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_CONV;
               end
            end
            ST_CONV: begin
               for (int k = 0; k < DIGITS; k++) begin
                  if (r_cnt == CW'(k)) begin
                     r_data_out[4*k +: 4] <= w_result;
                     r_err_mask[k]        <= w_invalid;
                  end
               end
               if (r_cnt == C_LAST) begin
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign data_out  = r_data_out;
   assign err_mask  = r_err_mask;
   assign err       = |r_err_mask;

endmodule

`default_nettype wire

// File: tb/tb_bcd_ex3_serial_conv.sv
//------------------------------------------------------------------------------
// Module  : tb_bcd_ex3_serial_conv
// Brief   : Self-checking bench for the 4-digit and 1-digit converter builds.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_ex3_serial_conv;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid, in_ready, mode, out_valid, out_ready, err;
   logic [15:0] data_in, data_out;
   logic [3:0]  err_mask;

   logic        in_valid1, in_ready1, mode1, out_valid1, out_ready1, err1;
   logic [3:0]  data_in1, data_out1;
   logic [0:0]  err_mask1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bcd_ex3_serial_conv #(.DIGITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .err_mask(err_mask), .err(err)
   );

   bcd_ex3_serial_conv #(.DIGITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .mode(mode1), .data_in(data_in1), .out_valid(out_valid1), .out_ready(out_ready1),
      .data_out(data_out1), .err_mask(err_mask1), .err(err1)
   );

   typedef struct {
      logic        m;
      logic [15:0] d;
      logic [15:0] ed;
      logic [3:0]  em;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: per-digit arithmetic on plain integers, result packed as {mask, data}.
   function automatic logic [19:0] model(input logic m, input logic [15:0] d);
      logic [15:0] od;
      logic [3:0]  om;
      int v, r;
      od = '0;
      om = '0;
      for (int k = 0; k < 4; k++) begin
         v = int'((d >> (4 * k)) & 16'hF);
         r = (m == 1'b0) ? v + 3 : v - 3;
         if ((m == 1'b0 && v <= 9) || (m == 1'b1 && r >= 0 && r <= 9)) begin
            od[4*k +: 4] = 4'(r);
         end else begin
            od[4*k +: 4] = 4'hF;
            om[k]        = 1'b1;
         end
      end
      return {om, od};
   endfunction

   task automatic start_word(input logic m, input logic [15:0] d);
      @(negedge clk);
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      mode     = m;
      data_in  = d;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      mode     = ~m;
      data_in  = ~d;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 64) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_word();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_after_release", 32'(out_valid), 32'd0);
      chk("in_ready_after_release", 32'(in_ready), 32'd1);
   endtask

   task automatic run_word(input string name, input logic m, input logic [15:0] d,
                           input logic [15:0] ed, input logic [3:0] em, input int hold);
      int lat;
      start_word(m, d);
      wait_done(lat);
      chk({name, "_latency"}, 32'(lat), 32'd4);
      chk({name, "_data"}, 32'(data_out), 32'(ed));
      chk({name, "_mask"}, 32'(err_mask), 32'(em));
      chk({name, "_err"}, 32'(err), 32'(|em));
      repeat (hold) @(negedge clk);
      release_word();
   endtask

   task automatic run1(input logic m, input logic [3:0] d, input logic [3:0] ed, input logic ee);
      int lat;
      @(negedge clk);
      in_valid1 = 1'b1;
      mode1     = m;
      data_in1  = d;
      @(posedge clk);
      @(negedge clk);
      in_valid1 = 1'b0;
      lat = 0;
      while (out_valid1 !== 1'b1 && lat < 16) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      chk("d1_latency", 32'(lat), 32'd1);
      chk("d1_data", 32'(data_out1), 32'(ed));
      chk("d1_err", 32'(err1), 32'(ee));
      chk("d1_mask", 32'(err_mask1), 32'(ee));
      out_ready1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready1 = 1'b0;
      chk("d1_out_valid_after_release", 32'(out_valid1), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      int          seen;
      logic        rm;
      logic [15:0] rd;
      logic [19:0] exp;

      vecs[0] = '{1'b0, 16'h1234, 16'h4567, 4'b0000};
      vecs[1] = '{1'b1, 16'h3C4B, 16'h0918, 4'b0000};
      vecs[2] = '{1'b0, 16'h9A05, 16'hCF38, 4'b0100};
      vecs[3] = '{1'b0, 16'h0000, 16'h3333, 4'b0000};
      vecs[4] = '{1'b1, 16'h0F21, 16'hFFFF, 4'b1111};
      vecs[5] = '{1'b1, 16'hCCCC, 16'h9999, 4'b0000};
      vecs[6] = '{1'b0, 16'h0999, 16'h3CCC, 4'b0000};

      rst_n = 1'b0;
      in_valid = 1'b0; mode = 1'b0; data_in = '0; out_ready = 1'b0;
      in_valid1 = 1'b0; mode1 = 1'b0; data_in1 = '0; out_ready1 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_err_mask", 32'(err_mask), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_d1_in_ready", 32'(in_ready1), 32'd1);

      for (int i = 0; i < 7; i++) begin
         run_word($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].ed, vecs[i].em, i % 3);
      end

      // Backpressure: result held in DONE while a new word is offered.
      start_word(1'b0, 16'h1234);
      wait_done(lat);
      chk("bp_latency", 32'(lat), 32'd4);
      in_valid = 1'b1;
      mode     = 1'b0;
      data_in  = 16'h5678;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp_data_stable", 32'(data_out), 32'h4567);
         chk("bp_in_ready_low", 32'(in_ready), 32'd0);
         chk("bp_out_valid_high", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_back_to_idle", 32'(in_ready), 32'd1);
      chk("bp_out_valid_fell", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_second_accepted", 32'(in_ready), 32'd0);
      wait_done(lat);
      chk("bp_second_latency", 32'(lat), 32'd4);
      chk("bp_second_data", 32'(data_out), 32'h89AB);
      release_word();

      // Reset in the middle of a conversion drops the word.
      start_word(1'b0, 16'h1234);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_data_out", 32'(data_out), 32'd0);
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      chk("midrst_no_stale_out", 32'(seen), 32'd0);
      run_word("midrst_next", 1'b0, 16'h0999, 16'h3CCC, 4'b0000, 0);

      // Single-digit build.
      run1(1'b0, 4'h9, 4'hC, 1'b0);
      run1(1'b1, 4'h2, 4'hF, 1'b1);
      run1(1'b1, 4'hC, 4'h9, 1'b0);

      // Randomised words against the reference model.
      for (int i = 0; i < 30; i++) begin
         rm  = 1'($urandom_range(0, 1));
         rd  = 16'($urandom);
         exp = model(rm, rd);
         run_word($sformatf("rand%0d", i), rm, rd, exp[15:0], exp[19:16], int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
